mem_subsystem: RTL

//  Memory slave directly downstream of the risc_v core: unified instruction/data RAM

---
 rtl/mem_subsystem.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_subsystem.sv
// rtl/mem_subsystem.sv - unified RAM plus MMIO slave for the risc_v core
//
// Purpose: one registered read port and one write port in front of a
// word-organised RAM. Handles funct3 lane selection, sign/zero extension
// of loads and byte-lane merging of stores.
// Optional feature macro: MEM_MMIO_EN (LED register, MICROS/MILLIS counters).
//
// Parameters:
//   DEPTH_WORDS  RAM size in 32-bit words (RAM spans 0 .. DEPTH_WORDS*4-1)
//   INIT_FILE    memory image path; preloading is left to the integration flow
//   CLK_FREQ_HZ  clk frequency, sets the microsecond prescaler
//   LED_W        width of the LED register / leds output
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_wen/wa/wd/wfunct3       write port (store width in wfunct3)
//   mem_ra/rfunct3              read address and load type, sampled at posedge
//   mem_rd                      registered, extended read data
//   leds                        LED register
module mem_subsystem #(
    parameter int    DEPTH_WORDS = 2048,
    parameter string INIT_FILE   = "",
    parameter int    CLK_FREQ_HZ = 12_000_000,
    parameter int    LED_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_wen,
    input  logic [31:0]      mem_wa,
    input  logic [31:0]      mem_wd,
    input  logic [2:0]       mem_wfunct3,
    input  logic [31:0]      mem_ra,
    input  logic [2:0]       mem_rfunct3,
    output logic [31:0]      mem_rd,
    output logic [LED_W-1:0] leds
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] mem [DEPTH_WORDS];

    logic        wa_in_ram;
    logic        ra_in_ram;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] rdata;

    assign wa_in_ram = (mem_wa < RAM_BYTES);
    assign ra_in_ram = (mem_ra < RAM_BYTES);

    // Store lane enables; a misaligned or unknown store yields wbe == 0,
    // which suppresses the write everywhere.
    always_comb begin
        wbe   = 4'b0000;
        wdata = 32'h0;
        case (mem_wfunct3)
            3'b000: begin
                wbe   = 4'b0001 << mem_wa[1:0];
                wdata = {4{mem_wd[7:0]}};
            end
            3'b001: begin
                if (!mem_wa[0]) begin
                    wbe   = mem_wa[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{mem_wd[15:0]}};
                end
            end
            3'b010: begin
                if (mem_wa[1:0] == 2'b00) begin
                    wbe   = 4'b1111;
                    wdata = mem_wd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_wen && wa_in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) mem[mem_wa[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

`ifdef MEM_MMIO_EN
    localparam int US_DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;

    logic [LED_W-1:0] led_q;
    logic [31:0]      led_word;
    logic [31:0]      led_merged;
    logic [31:0]      us_presc;
    logic [9:0]       ms_presc;
    logic [31:0]      micros;
    logic [31:0]      millis;
    logic             us_tick;
    logic             ms_tick;

    assign led_word = 32'(led_q);
    assign us_tick  = (us_presc == 32'(US_DIV - 1));
    assign ms_tick  = us_tick && (ms_presc == 10'd999);

    always_comb begin
        led_merged = led_word;
        for (int i = 0; i < 4; i++) begin
            if (wbe[i]) led_merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= '0;
            us_presc <= '0;
            ms_presc <= '0;
            micros   <= '0;
            millis   <= '0;
        end else begin
            if (mem_wen && mem_wa[31:2] == 30'h3FFF_FFFF) led_q <= led_merged[LED_W-1:0];
            us_presc <= us_tick ? 32'h0 : us_presc + 32'h1;
            if (us_tick) begin
                micros   <= micros + 32'h1;
                ms_presc <= (ms_presc == 10'd999) ? 10'd0 : ms_presc + 10'd1;
            end
            if (ms_tick) millis <= millis + 32'h1;
        end
    end

    assign leds = led_q;
`else
    assign leds = '0;
`endif

    // Word source; counter reads see the value before this edge's increment
    // because the counters update with non-blocking assignments.
    always_comb begin
        rword = 32'h0;
        if (ra_in_ram) rword = mem[mem_ra[AW+1:2]];
`ifdef MEM_MMIO_EN
        else if (mem_ra[31:2] == 30'h3FFF_FFFF) rword = led_word;
        else if (mem_ra[31:2] == 30'h3FFF_FFFE) rword = millis;
        else if (mem_ra[31:2] == 30'h3FFF_FFFD) rword = micros;
`endif
    end

    assign rshift = rword >> {mem_ra[1:0], 3'b000};

    always_comb begin
        rdata = 32'h0;
        case (mem_rfunct3)
            3'b000: rdata = {{24{rshift[7]}}, rshift[7:0]};
            3'b100: rdata = {24'h0, rshift[7:0]};
            3'b001: if (!mem_ra[0]) rdata = {{16{rshift[15]}}, rshift[15:0]};
            3'b101: if (!mem_ra[0]) rdata = {16'h0, rshift[15:0]};
            3'b010: if (mem_ra[1:0] == 2'b00) rdata = rword;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) mem_rd <= 32'h0;
        else     mem_rd <= rdata;
    end

endmodule
